// File: rtl/forney_frame_ctrl.sv
// Per-codeword frame controller for the Forney error-value stage.
// Counts Chien root hits and Forney corrections for each codeword. It checks
// them against the latched error-locator degree and reports the codeword's
// completion, failure or abort as single-cycle registered pulses.
module forney_frame_ctrl #(
  parameter int unsigned LANES     = 32,
  parameter int unsigned T         = 11,
  parameter int unsigned CHIEN_CYC = 17,
  parameter int unsigned DRAIN_TO  = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [3:0]       deg_i,
  output logic             start_rdy_o,
  input  logic             chien_vld_i,
  input  logic [LANES-1:0] hit_mask_i,
  input  logic             corr_vld_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             flush_o,
  output logic             done_o,
  output logic             fail_o,
  output logic [4:0]       err_cnt_o
);

  localparam int unsigned CYC_W = (CHIEN_CYC > 1) ? $clog2(CHIEN_CYC) : 1;
  localparam int unsigned TMO_W = (DRAIN_TO > 1) ? $clog2(DRAIN_TO) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    CHECK  = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t           state;
  logic [3:0]       deg_q;
  logic [4:0]       hit_cnt;
  logic [4:0]       corr_cnt;
  logic [CYC_W-1:0] cyc_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic [31:0]      pop;
  logic [31:0]      hit_sum;
  logic [4:0]       hit_nxt;
  logic [4:0]       corr_nxt;
  logic             chk_fail;
  logic             fin;
  logic             fin_fail;

  // Saturating next-count values and the CHECK verdict.
  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      pop = pop + 32'(hit_mask_i[i]);
    end
    hit_sum  = 32'(hit_cnt) + pop;
    hit_nxt  = (hit_sum > 32'd31) ? 5'd31 : hit_sum[4:0];
    corr_nxt = (corr_vld_i && (corr_cnt != 5'd31)) ? corr_cnt + 5'd1 : corr_cnt;
    chk_fail = (32'(deg_q) > T) || (hit_cnt != {1'b0, deg_q}) || (corr_cnt > hit_cnt);
  end

  // Completion decision for the current cycle. In DRAIN it uses the count that includes this cycle's pulse.
  always_comb begin
    fin      = 1'b0;
    fin_fail = 1'b0;
    case (state)
      CHECK: begin
        fin      = chk_fail || (corr_cnt == hit_cnt);
        fin_fail = chk_fail;
      end
      DRAIN: begin
        if (corr_nxt == hit_cnt) begin
          fin = 1'b1;
        end else if ((corr_nxt > hit_cnt) || (tmo_cnt == TMO_W'(DRAIN_TO - 1))) begin
          fin      = 1'b1;
          fin_fail = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Frame FSM with counters and registered pulse outputs.
  // Abort is tested ahead of completion so that it overrides a completion in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      deg_q     <= '0;
      hit_cnt   <= '0;
      corr_cnt  <= '0;
      cyc_cnt   <= '0;
      tmo_cnt   <= '0;
      done_o    <= 1'b0;
      fail_o    <= 1'b0;
      flush_o   <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      done_o    <= 1'b0;
      fail_o    <= 1'b0;
      flush_o   <= 1'b0;
      err_cnt_o <= '0;
      if ((state != IDLE) && abort_i) begin
        state   <= IDLE;
        flush_o <= 1'b1;
      end else if (fin) begin
        state     <= IDLE;
        done_o    <= 1'b1;
        fail_o    <= fin_fail;
        flush_o   <= fin_fail;
        err_cnt_o <= hit_cnt;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              deg_q    <= deg_i;
              hit_cnt  <= '0;
              corr_cnt <= '0;
              cyc_cnt  <= '0;
              tmo_cnt  <= '0;
              state    <= SEARCH;
            end
          end
          SEARCH: begin
            corr_cnt <= corr_nxt;
            if (chien_vld_i) begin
              hit_cnt <= hit_nxt;
              cyc_cnt <= cyc_cnt + CYC_W'(1);
              if (cyc_cnt == CYC_W'(CHIEN_CYC - 1)) begin
                state <= CHECK;
              end
            end
          end
          CHECK: begin
            corr_cnt <= corr_nxt;
            state    <= DRAIN;
          end
          DRAIN: begin
            corr_cnt <= corr_nxt;
            tmo_cnt  <= tmo_cnt + TMO_W'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign start_rdy_o = (state == IDLE);
  assign busy_o      = (state != IDLE);

endmodule
